apb_arbiter: RTL and testbench

APB_ARBITER -- requirements
Module: apb_arbiter

---
 rtl/apb_arbiter_if.sv | 38 +++
 rtl/apb_arbiter.sv | 127 ++++++++++++
 tb/tb_apb_arbiter.sv | 345 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/apb_arbiter_if.sv
// Requester-side and APB-side signal bundle for apb_arbiter.
// master = arbiter view, slave = environment (requesters + APB slave) view.
interface apb_arbiter_if;
    logic [3:0]   req;
    logic [127:0] req_addr;
    logic [3:0]   req_write;
    logic [127:0] req_wdata;
    logic [15:0]  req_strb;
    logic [11:0]  req_prot;
    logic [3:0]   gnt;
    logic [3:0]   done;
    logic [31:0]  rdata;
    logic         err;
    logic [31:0]  paddr;
    logic         pwrite;
    logic [2:0]   pprot;
    logic [31:0]  pwdata;
    logic [3:0]   pstrb;
    logic [3:0]   psel;
    logic         penable;
    logic [31:0]  prdata;
    logic         pready;
    logic         pslverr;

    modport master (
        input  req, req_addr, req_write, req_wdata, req_strb, req_prot,
        input  prdata, pready, pslverr,
        output gnt, done, rdata, err,
        output paddr, pwrite, pprot, pwdata, pstrb, psel, penable
    );

    modport slave (
        output req, req_addr, req_write, req_wdata, req_strb, req_prot,
        output prdata, pready, pslverr,
        input  gnt, done, rdata, err,
        input  paddr, pwrite, pprot, pwdata, pstrb, psel, penable
    );
endinterface

// File: rtl/apb_arbiter.sv
// Four-requester round-robin arbiter driving one APB master port (IDLE/SETUP/ACCESS).
// Define APB_TIMEOUT_EN to end ACCESS with err=1 after TIMEOUT_CYCLES wait cycles.
module apb_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input logic           pclk,
    input logic           preset,
    apb_arbiter_if.master bus
);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    state_t      state;
    logic [1:0]  last;
    logic        win_vld;
    logic [1:0]  win_idx;
    logic [1:0]  cand;
    logic        mask_last;
    logic        tmo;
    logic        complete;
    logic        launch;
    logic [3:0]  prot_lsb;
    logic [31:0] win_addr;
    logic [31:0] win_wdata;
    logic [3:0]  win_strb;
    logic [2:0]  win_prot;
    logic        win_write;

    if (TIMEOUT_CYCLES == 0) begin : g_cfg_check
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    // Scan from the highest offset down so the nearest requester after `last` wins.
    always_comb begin
        win_vld = 1'b0;
        win_idx = last;
        cand    = '0;
        for (int k = 4; k >= 1; k--) begin
            cand = last + 2'(k);
            if (bus.req[cand] && !(mask_last && cand == last)) begin
                win_vld = 1'b1;
                win_idx = cand;
            end
        end
    end

    assign mask_last = (state == ACCESS);
    assign prot_lsb  = 4'(win_idx) * 4'd3;
    assign win_addr  = bus.req_addr[{win_idx, 5'd0} +: 32];
    assign win_wdata = bus.req_wdata[{win_idx, 5'd0} +: 32];
    assign win_strb  = bus.req_strb[{win_idx, 2'd0} +: 4];
    assign win_prot  = bus.req_prot[prot_lsb +: 3];
    assign win_write = bus.req_write[win_idx];

`ifdef APB_TIMEOUT_EN
    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] wait_cnt;

    assign tmo = (state == ACCESS) && !bus.pready && (wait_cnt == CW'(TIMEOUT_CYCLES - 1));

    // Consecutive ACCESS cycles without pready; cleared outside ACCESS.
    always_ff @(posedge pclk) begin
        if (preset || state != ACCESS) begin
            wait_cnt <= '0;
        end else if (!bus.pready) begin
            wait_cnt <= wait_cnt + CW'(1);
        end
    end
`else
    assign tmo = 1'b0;
`endif

    assign complete = (state == ACCESS) && (bus.pready || tmo);
    assign launch   = win_vld && ((state == IDLE) || complete);

    always_ff @(posedge pclk) begin
        if (preset) begin
            state       <= IDLE;
            last        <= 2'd3;
            bus.gnt     <= '0;
            bus.done    <= '0;
            bus.rdata   <= '0;
            bus.err     <= 1'b0;
            bus.psel    <= '0;
            bus.penable <= 1'b0;
            bus.paddr   <= '0;
            bus.pwrite  <= 1'b0;
            bus.pprot   <= '0;
            bus.pwdata  <= '0;
            bus.pstrb   <= '0;
        end else begin
            bus.done <= '0;
            case (state)
                SETUP: begin
                    state       <= ACCESS;
                    bus.penable <= 1'b1;
                end
                ACCESS: begin
                    if (complete) begin
                        bus.done    <= bus.gnt;
                        bus.rdata   <= (tmo || bus.pwrite) ? '0 : bus.prdata;
                        bus.err     <= tmo | bus.pslverr;
                        bus.penable <= 1'b0;
                        bus.gnt     <= '0;
                        bus.psel    <= '0;
                        state       <= IDLE;
                    end
                end
                default: ;
            endcase
            // A new grant overrides the IDLE fall-through, giving back-to-back SETUPs.
            if (launch) begin
                state       <= SETUP;
                last        <= win_idx;
                bus.gnt     <= 4'(4'b0001 << win_idx);
                bus.psel    <= 4'(4'b0001 << win_addr[31:30]);
                bus.penable <= 1'b0;
                bus.paddr   <= win_addr;
                bus.pwrite  <= win_write;
                bus.pprot   <= win_prot;
                bus.pwdata  <= win_wdata;
                bus.pstrb   <= win_strb;
            end
        end
    end

endmodule

// File: tb/tb_apb_arbiter.sv
// Self-checking bench for apb_arbiter: directed scenarios plus randomized traffic
// against a transaction-level round-robin reference model.
module tb_apb_arbiter;
    localparam int unsigned TMO = 16;

    logic pclk;
    logic preset;
    apb_arbiter_if bus();

    apb_arbiter #(.TIMEOUT_CYCLES(TMO)) dut (.pclk(pclk), .preset(preset), .bus(bus));

    int total = 0;
    int bad   = 0;

    logic [31:0] a_addr[4];
    logic [31:0] a_wdata[4];
    logic        a_write[4];
    logic [3:0]  a_strb[4];
    logic [2:0]  a_prot[4];

    // reference model state
    int          m_owner;
    int          m_last;
    bit          m_setup;
    int          m_wait;
    logic [31:0] m_addr, m_wdata;
    logic        m_write;
    logic [3:0]  m_strb;
    logic [2:0]  m_prot;
    logic [3:0]  exp_done;
    logic [31:0] exp_rdata;
    logic        exp_err;

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    task automatic tick();
        @(posedge pclk);
        @(negedge pclk);
    endtask

    task automatic drive_fields();
        for (int i = 0; i < 4; i++) begin
            bus.req_addr[i*32 +: 32]  = a_addr[i];
            bus.req_wdata[i*32 +: 32] = a_wdata[i];
            bus.req_write[i]          = a_write[i];
            bus.req_strb[i*4 +: 4]    = a_strb[i];
            bus.req_prot[i*3 +: 3]    = a_prot[i];
        end
    endtask

    task automatic rand_fields(input int i);
        a_addr[i]  = $urandom;
        a_wdata[i] = $urandom;
        a_write[i] = 1'($urandom_range(1));
        a_strb[i]  = 4'($urandom);
        a_prot[i]  = 3'($urandom);
    endtask

    function automatic int rr_pick(input logic [3:0] r, input int from, input bit mask);
        for (int k = 1; k <= 4; k++) begin
            int j;
            j = (from + k) % 4;
            if (r[j] && !(mask && j == from)) return j;
        end
        return -1;
    endfunction

    function automatic void m_grant(input int w);
        if (w < 0) begin
            m_owner = -1;
        end else begin
            m_owner = w;
            m_last  = w;
            m_setup = 1'b1;
            m_wait  = 0;
            m_addr  = a_addr[w];
            m_wdata = a_wdata[w];
            m_write = a_write[w];
            m_strb  = a_strb[w];
            m_prot  = a_prot[w];
        end
    endfunction

    // Advance the model across one rising edge using the inputs currently driven.
    function automatic void model_step();
        bit fin;
        bit to;
        exp_done = '0;
        fin = 1'b0;
        to  = 1'b0;
        if (m_owner < 0) begin
            m_grant(rr_pick(bus.req, m_last, 1'b0));
        end else if (m_setup) begin
            m_setup = 1'b0;
        end else begin
            fin = bus.pready;
`ifdef APB_TIMEOUT_EN
            if (!bus.pready) begin
                m_wait++;
                if (m_wait == int'(TMO)) begin
                    fin = 1'b1;
                    to  = 1'b1;
                end
            end
`endif
            if (fin) begin
                exp_done  = 4'(1 << m_owner);
                exp_rdata = (to || m_write) ? 32'h0 : bus.prdata;
                exp_err   = to ? 1'b1 : bus.pslverr;
                m_grant(rr_pick(bus.req, m_owner, 1'b1));
            end
        end
    endfunction

    task automatic do_reset();
        preset      = 1'b1;
        bus.req     = '0;
        bus.pready  = 1'b0;
        bus.pslverr = 1'b0;
        bus.prdata  = '0;
        for (int i = 0; i < 4; i++) rand_fields(i);
        drive_fields();
        tick();
        tick();
        preset   = 1'b0;
        m_owner  = -1;
        m_last   = 3;
        m_setup  = 1'b0;
        m_wait   = 0;
        exp_done = '0;
    endtask

    task automatic test_reset();
        preset     = 1'b1;
        bus.req    = 4'hF;
        bus.pready = 1'b1;
        bus.prdata = 32'hFFFF_FFFF;
        for (int i = 0; i < 4; i++) rand_fields(i);
        drive_fields();
        tick();
        tick();
        total++; if (bus.gnt !== 4'h0) begin bad++; $display("FAIL reset_gnt got=%h exp=0", bus.gnt); end
        total++; if (bus.done !== 4'h0) begin bad++; $display("FAIL reset_done got=%h exp=0", bus.done); end
        total++; if (bus.psel !== 4'h0 || bus.penable !== 1'b0) begin bad++; $display("FAIL reset_psel got=%h/%b exp=0/0", bus.psel, bus.penable); end
        total++; if (bus.rdata !== 32'h0 || bus.err !== 1'b0) begin bad++; $display("FAIL reset_rdata got=%h/%b exp=0/0", bus.rdata, bus.err); end
        total++;
        if (bus.paddr !== 32'h0 || bus.pwdata !== 32'h0 || bus.pwrite !== 1'b0 || bus.pstrb !== 4'h0 || bus.pprot !== 3'h0) begin
            bad++; $display("FAIL reset_fields got=%h/%h/%b/%h/%h exp=all 0", bus.paddr, bus.pwdata, bus.pwrite, bus.pstrb, bus.pprot);
        end
        bus.req = '0;
        preset  = 1'b0;
    endtask

    task automatic test_single_read();
        do_reset();
        a_addr[0] = 32'h4000_0010; a_write[0] = 1'b0; a_prot[0] = 3'b010; a_strb[0] = 4'hF;
        drive_fields();
        bus.req = 4'b0001; bus.prdata = 32'hDEAD_BEEF; bus.pready = 1'b1; bus.pslverr = 1'b0;
        tick();
        total++; if (bus.gnt !== 4'b0001) begin bad++; $display("FAIL rd_setup_gnt got=%h exp=1", bus.gnt); end
        total++; if (bus.psel !== 4'b0010 || bus.penable !== 1'b0) begin bad++; $display("FAIL rd_setup_psel got=%h/%b exp=2/0", bus.psel, bus.penable); end
        total++; if (bus.paddr !== 32'h4000_0010 || bus.pprot !== 3'b010) begin bad++; $display("FAIL rd_setup_addr got=%h/%h exp=40000010/2", bus.paddr, bus.pprot); end
        tick();
        total++; if (bus.penable !== 1'b1 || bus.psel !== 4'b0010) begin bad++; $display("FAIL rd_access got=%b/%h exp=1/2", bus.penable, bus.psel); end
        tick();
        total++; if (bus.done !== 4'b0001) begin bad++; $display("FAIL rd_done got=%h exp=1", bus.done); end
        total++; if (bus.rdata !== 32'hDEAD_BEEF || bus.err !== 1'b0) begin bad++; $display("FAIL rd_data got=%h/%b exp=deadbeef/0", bus.rdata, bus.err); end
        total++; if (bus.gnt !== 4'h0 || bus.psel !== 4'h0) begin bad++; $display("FAIL rd_idle got=%h/%h exp=0/0", bus.gnt, bus.psel); end
        bus.req = '0;
        tick();
        total++; if (bus.done !== 4'h0) begin bad++; $display("FAIL rd_done_pulse got=%h exp=0", bus.done); end
    endtask

    task automatic test_contention();
        int order[5] = '{0, 1, 2, 3, 0};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            a_addr[i]  = {2'(3 - i), 30'h100 + 30'(i)};
            a_write[i] = 1'b1;
        end
        drive_fields();
        bus.req = 4'hF; bus.pready = 1'b1;
        tick();
        for (int k = 0; k < 5; k++) begin
            logic [3:0] eg;
            logic [3:0] es;
            eg = 4'(1 << order[k]);
            es = 4'(1 << (3 - order[k]));
            total++; if (bus.gnt !== eg || bus.penable !== 1'b0) begin bad++; $display("FAIL rr_setup%0d got=%h/%b exp=%h/0", k, bus.gnt, bus.penable, eg); end
            total++; if (bus.psel !== es) begin bad++; $display("FAIL rr_psel%0d got=%h exp=%h", k, bus.psel, es); end
            tick();
            total++; if (bus.penable !== 1'b1 || bus.gnt !== eg) begin bad++; $display("FAIL rr_access%0d got=%b/%h exp=1/%h", k, bus.penable, bus.gnt, eg); end
            tick();
            total++; if (bus.done !== eg) begin bad++; $display("FAIL rr_done%0d got=%h exp=%h", k, bus.done, eg); end
        end
    endtask

    task automatic test_wait_states();
        do_reset();
        a_addr[2] = 32'hC000_0004; a_write[2] = 1'b1; a_wdata[2] = 32'h1234_5678;
        a_strb[2] = 4'hF; a_prot[2] = 3'b101;
        drive_fields();
        bus.req = 4'b0100; bus.pready = 1'b0; bus.pslverr = 1'b0; bus.prdata = 32'hAAAA_5555;
        tick();
        total++; if (bus.gnt !== 4'b0100 || bus.psel !== 4'b1000) begin bad++; $display("FAIL ws_setup got=%h/%h exp=4/8", bus.gnt, bus.psel); end
        tick();
        for (int i = 0; i < 4; i++) begin
            total++; if (bus.penable !== 1'b1 || bus.done !== 4'h0) begin bad++; $display("FAIL ws_access%0d got=%b/%h exp=1/0", i, bus.penable, bus.done); end
            total++;
            if (bus.paddr !== 32'hC000_0004 || bus.pwdata !== 32'h1234_5678 || bus.pwrite !== 1'b1 || bus.pstrb !== 4'hF || bus.pprot !== 3'b101) begin
                bad++; $display("FAIL ws_fields%0d got=%h/%h/%b/%h/%h", i, bus.paddr, bus.pwdata, bus.pwrite, bus.pstrb, bus.pprot);
            end
            if (i == 3) begin bus.pready = 1'b1; bus.pslverr = 1'b1; end
            tick();
        end
        total++; if (bus.done !== 4'b0100 || bus.err !== 1'b1) begin bad++; $display("FAIL ws_done got=%h/%b exp=4/1", bus.done, bus.err); end
        total++; if (bus.rdata !== 32'h0) begin bad++; $display("FAIL ws_rdata got=%h exp=0", bus.rdata); end
        bus.req = '0; bus.pready = 1'b0; bus.pslverr = 1'b0;
    endtask

    task automatic test_req_drop();
        do_reset();
        a_write[3] = 1'b0;
        drive_fields();
        bus.req = 4'b1000; bus.pready = 1'b1; bus.prdata = 32'h0BAD_F00D;
        tick();
        bus.req = '0;
        tick();
        total++; if (bus.penable !== 1'b1 || bus.gnt !== 4'b1000) begin bad++; $display("FAIL drop_access got=%b/%h exp=1/8", bus.penable, bus.gnt); end
        tick();
        total++; if (bus.done !== 4'b1000 || bus.rdata !== 32'h0BAD_F00D) begin bad++; $display("FAIL drop_done got=%h/%h exp=8/0badf00d", bus.done, bus.rdata); end
    endtask

    task automatic test_reset_in_access();
        do_reset();
        a_write[0] = 1'b0; a_write[1] = 1'b0;
        drive_fields();
        bus.req = 4'b0001; bus.pready = 1'b1; bus.prdata = 32'h1357_9BDF;
        tick(); tick(); tick();
        bus.req = 4'b0010; bus.pready = 1'b0;
        tick(); tick();
        total++; if (bus.penable !== 1'b1 || bus.gnt !== 4'b0010) begin bad++; $display("FAIL rst_pre got=%b/%h exp=1/2", bus.penable, bus.gnt); end
        preset = 1'b1;
        tick();
        preset = 1'b0; bus.req = '0;
        total++; if (bus.gnt !== 4'h0 || bus.psel !== 4'h0 || bus.penable !== 1'b0) begin bad++; $display("FAIL rst_abort got=%h/%h/%b exp=0/0/0", bus.gnt, bus.psel, bus.penable); end
        total++; if (bus.rdata !== 32'h0 || bus.err !== 1'b0 || bus.paddr !== 32'h0) begin bad++; $display("FAIL rst_abort_data got=%h/%b/%h exp=0/0/0", bus.rdata, bus.err, bus.paddr); end
        total++; if (bus.done !== 4'h0) begin bad++; $display("FAIL rst_abort_done got=%h exp=0", bus.done); end
        tick();
        total++; if (bus.done !== 4'h0 || bus.gnt !== 4'h0) begin bad++; $display("FAIL rst_idle got=%h/%h exp=0/0", bus.done, bus.gnt); end
    endtask

    task automatic test_timeout();
        int  n_acc;
        bit  seen;
        do_reset();
        a_write[0] = 1'b0;
        drive_fields();
        bus.req = 4'b0001; bus.pready = 1'b0; bus.prdata = 32'hFACE_CAFE;
        tick();
        n_acc = 0;
        seen  = 1'b0;
        for (int c = 0; c < 100 && !seen; c++) begin
            tick();
            if (bus.done !== 4'h0) seen = 1'b1;
            else if (bus.penable === 1'b1) n_acc++;
        end
`ifdef APB_TIMEOUT_EN
        total++; if (!seen || n_acc != int'(TMO)) begin bad++; $display("FAIL tmo_cycles got=%0d seen=%0d exp=%0d", n_acc, seen, TMO); end
        total++; if (bus.done !== 4'b0001 || bus.err !== 1'b1 || bus.rdata !== 32'h0) begin bad++; $display("FAIL tmo_done got=%h/%b/%h exp=1/1/0", bus.done, bus.err, bus.rdata); end
`else
        total++; if (seen) begin bad++; $display("FAIL tmo_nodone got=done after %0d cycles exp=none", n_acc); end
        total++; if (bus.penable !== 1'b1 || bus.gnt !== 4'b0001) begin bad++; $display("FAIL tmo_wait got=%b/%h exp=1/1", bus.penable, bus.gnt); end
`endif
        bus.req = '0;
    endtask

    task automatic test_random();
        do_reset();
        model_step();
        tick();
        for (int cyc = 0; cyc < 600; cyc++) begin
            logic [3:0] eg;
            eg = (m_owner >= 0) ? 4'(1 << m_owner) : 4'h0;
            total++; if (bus.gnt !== eg) begin bad++; $display("FAIL rnd_gnt cyc=%0d got=%h exp=%h", cyc, bus.gnt, eg); end
            total++; if (bus.penable !== (m_owner >= 0 && !m_setup)) begin bad++; $display("FAIL rnd_penable cyc=%0d got=%b", cyc, bus.penable); end
            total++; if (bus.done !== exp_done) begin bad++; $display("FAIL rnd_done cyc=%0d got=%h exp=%h", cyc, bus.done, exp_done); end
            if (exp_done != 4'h0) begin
                total++; if (bus.rdata !== exp_rdata || bus.err !== exp_err) begin bad++; $display("FAIL rnd_resp cyc=%0d got=%h/%b exp=%h/%b", cyc, bus.rdata, bus.err, exp_rdata, exp_err); end
            end
            if (m_owner >= 0) begin
                total++;
                if (bus.paddr !== m_addr || bus.pwdata !== m_wdata || bus.pwrite !== m_write || bus.pstrb !== m_strb || bus.pprot !== m_prot) begin
                    bad++; $display("FAIL rnd_fields cyc=%0d got=%h/%h exp=%h/%h", cyc, bus.paddr, bus.pwdata, m_addr, m_wdata);
                end
                total++; if (bus.psel !== 4'(1 << m_addr[31:30])) begin bad++; $display("FAIL rnd_psel cyc=%0d got=%h addr=%h", cyc, bus.psel, m_addr); end
            end else begin
                total++; if (bus.psel !== 4'h0) begin bad++; $display("FAIL rnd_psel_idle cyc=%0d got=%h exp=0", cyc, bus.psel); end
            end
            for (int i = 0; i < 4; i++) begin
                if (exp_done[i]) bus.req[i] = 1'b0;
                else if (!bus.req[i] && $urandom_range(2) == 0) begin
                    rand_fields(i);
                    bus.req[i] = 1'b1;
                end
            end
            drive_fields();
            bus.pready  = ($urandom_range(3) != 0);
            bus.prdata  = $urandom;
            bus.pslverr = ($urandom_range(7) == 0);
            model_step();
            tick();
        end
        bus.req = '0;
    endtask

    initial begin
        preset      = 1'b1;
        bus.req     = '0;
        bus.pready  = 1'b0;
        bus.pslverr = 1'b0;
        bus.prdata  = '0;
        for (int i = 0; i < 4; i++) rand_fields(i);
        drive_fields();
        @(negedge pclk);
        test_reset();
        test_single_read();
        test_contention();
        test_wait_states();
        test_req_drop();
        test_reset_in_access();
        test_timeout();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
